// File: rtl/pipeline_debug_unit.sv
// Run-control and state-dump unit for a 5-stage pipeline: gates all stages through
// one clock enable and streams a cycle-count-prefixed state snapshot as bytes.
module pipeline_debug_unit #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inCmdValid,
    input  logic [7:0]                    inCmd,
    output logic                          outCmdReady,
    input  logic                          inHalt,
    output logic                          outPipeEnable,
    input  logic [DATA_W*NUM_WORDS-1:0]   inSnapData,
    output logic                          outTxValid,
    output logic [7:0]                    outTxByte,
    input  logic                          inTxReady,
    output logic [DATA_W-1:0]             outCycleCount,
    output logic                          outHalted,
    output logic                          outBusy
);

    localparam int BPW   = DATA_W / 8;
    localparam int TOTAL = (NUM_WORDS + 1) * BPW;
    localparam int IDX_W = $clog2(TOTAL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    localparam logic [7:0] CMD_RUN  = 8'h01;
    localparam logic [7:0] CMD_STEP = 8'h02;
    localparam logic [7:0] CMD_DUMP = 8'h03;
    localparam logic [7:0] CMD_CLR  = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] count_r;
    logic              halted_r;
    logic              tx_valid_r;
    logic [7:0]        tx_byte_r;
    logic [IDX_W-1:0]  idx_r;
    logic [7:0]        buf_r [TOTAL];

    logic              cmd_fire_s;
    logic              tx_fire_s;
    logic              enable_s;
    logic [IDX_W-1:0]  next_idx_s;

    assign cmd_fire_s = inCmdValid && (state_r == ST_IDLE);
    assign tx_fire_s  = tx_valid_r && inTxReady;
    assign enable_s   = (state_r == ST_RUN) || (state_r == ST_STEP);
    assign next_idx_s = idx_r + IDX_W'(1);

    assign outCmdReady   = (state_r == ST_IDLE);
    assign outBusy       = (state_r != ST_IDLE);
    assign outPipeEnable = enable_s;
    assign outTxValid    = tx_valid_r;
    assign outTxByte     = tx_byte_r;
    assign outCycleCount = count_r;
    assign outHalted     = halted_r;

    // Run-control state machine, cycle counter, halt flag and byte-stream sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            count_r    <= '0;
            halted_r   <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_byte_r  <= 8'h00;
            idx_r      <= '0;
        end else begin
            if (enable_s) begin
                count_r <= count_r + DATA_W'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        case (inCmd)
                            CMD_RUN: begin
                                // A halted pipeline stays frozen until CLR.
                                if (!halted_r) begin
                                    state_r <= ST_RUN;
                                end
                            end
                            CMD_STEP: begin
                                if (!halted_r) begin
                                    state_r <= ST_STEP;
                                end
                            end
                            CMD_DUMP: begin
                                state_r    <= ST_DUMP;
                                tx_valid_r <= 1'b1;
                                tx_byte_r  <= count_r[7:0];
                                idx_r      <= '0;
                            end
                            CMD_CLR: begin
                                count_r  <= '0;
                                halted_r <= 1'b0;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    if (inHalt) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (inHalt) begin
                        halted_r <= 1'b1;
                    end
                    state_r <= ST_IDLE;
                end
                ST_DUMP: begin
                    if (tx_fire_s) begin
                        if (idx_r == LAST_IDX) begin
                            tx_valid_r <= 1'b0;
                            tx_byte_r  <= 8'h00;
                            idx_r      <= '0;
                            state_r    <= ST_IDLE;
                        end else begin
                            idx_r     <= next_idx_s;
                            tx_byte_r <= buf_r[next_idx_s];
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Snapshot buffer: cycle count as word 0, then the state words, LSB-first bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TOTAL; i++) begin
                buf_r[i] <= 8'h00;
            end
        end else if (cmd_fire_s && (inCmd == CMD_DUMP)) begin
            for (int b = 0; b < BPW; b++) begin
                buf_r[b] <= count_r[b*8 +: 8];
            end
            for (int w = 0; w < NUM_WORDS; w++) begin
                for (int b = 0; b < BPW; b++) begin
                    buf_r[(w+1)*BPW + b] <= inSnapData[w*DATA_W + b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: doc/pipeline_debug_unit.md
Name: pipeline_debug_unit

Overview:
Run-control and state-dump unit for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It gates every stage through a shared clock enable. It supports free-run until a halt instruction retires and single-step. On command it serialises a parametrised snapshot of pipeline state, prefixed by a cycle counter, as a byte stream with a valid/ready handshake. It sits between the command/serial front end and the pipeline top level.

Parameters:
DATA_W, 32, width of each snapshot word and of the cycle counter; must be a multiple of 8
NUM_WORDS, 8, number of snapshot words on inSnapData; minimum 1

Ports:
clk  in  1  system clock; all logic is rising-edge
rst  in  1  reset, asynchronous, active-high
inCmdValid  in  1  command strobe
inCmd  in  8  opcode: 0x01 RUN, 0x02 STEP, 0x03 DUMP, 0x04 CLR
outCmdReady  out  1  unit can accept a command
inHalt  in  1  halt instruction present in WB this cycle
outPipeEnable  out  1  clock enable to all pipeline stages and stage registers
inSnapData  in  DATA_W*NUM_WORDS  flattened state; word i = inSnapData[i*DATA_W +: DATA_W]
outTxValid  out  1  outTxByte is valid
outTxByte  out  8  dump byte
inTxReady  in  1  consumer accepts byte
outCycleCount  out  DATA_W  number of enabled pipeline cycles
outHalted  out  1  sticky: halt has been seen
outBusy  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE
  - outPipeEnable = 0, outTxValid = 0, outTxByte = 0x00, outCycleCount = 0, outHalted = 0, outBusy = 0, outCmdReady = 1
  - byte index and capture buffer cleared
- States: IDLE, RUN, STEP, DUMP.
- outCmdReady = 1 only in IDLE. A command is accepted on a rising edge with inCmdValid & outCmdReady. Commands offered outside IDLE are not accepted; the source must hold them.
- IDLE:
  - RUN -> RUN
  - STEP -> STEP
  - DUMP -> DUMP
  - CLR -> clears outCycleCount and outHalted; stays IDLE
  - any other opcode -> accepted and ignored; stays IDLE
  - RUN or STEP while outHalted = 1 -> accepted as a no-op; stays IDLE with no enable pulse
- outPipeEnable is combinational: 1 exactly when state is RUN or STEP; 0 otherwise.
- outCycleCount increments by 1 on every edge where outPipeEnable = 1. It wraps from 2^DATA_W-1 to 0 with no flag.
- RUN:
  - Enable stays high each cycle.
  - If inHalt = 1 on an edge: that cycle is counted, outHalted <= 1, next state IDLE.
  - Otherwise the unit remains in RUN indefinitely.
- STEP:
  - Exactly one enabled cycle, then IDLE.
  - inHalt = 1 during that cycle sets outHalted.
- inHalt is ignored whenever outPipeEnable = 0.
- DUMP:
  - On acceptance, capture outCycleCount (pre-dump value) as word 0 and inSnapData words 0..NUM_WORDS-1 as words 1..NUM_WORDS into a buffer. Later changes on inSnapData do not affect the transfer.
  - Total bytes = (NUM_WORDS+1)*DATA_W/8.
  - Order: word 0 first; within each word, least-significant byte first.
  - outTxValid rises the cycle after acceptance.
  - outTxByte is stable while outTxValid & !inTxReady.
  - On each edge with outTxValid & inTxReady, the index advances and the next byte is presented the same edge (no bubble).
  - After the last transfer: outTxValid = 0 and state IDLE on that edge.
  - The pipeline is frozen (enable 0) throughout.
- outBusy = (state != IDLE).
- Reset mid-RUN or mid-DUMP aborts immediately. The stream is truncated with no trailing byte.

Test Plan:
(All scenarios use DATA_W=32, NUM_WORDS=2.)
1. Reset -> outCmdReady = 1; all other outputs 0; outTxByte = 0x00.
2. Three STEP commands spaced 4 cycles apart -> three single-cycle outPipeEnable pulses; outCycleCount = 3; outBusy high for one cycle each.
3. RUN, with inHalt asserted on the 10th enabled cycle -> outCycleCount = 10, outHalted = 1, enable low on the next cycle. A subsequent RUN is accepted, enable stays 0, and the count remains 10.
4. DUMP with word0 = 0x11223344, word1 = 0xAABBCCDD, count = 10, and inTxReady randomly toggled -> exactly 12 handshakes: 0A 00 00 00 44 33 22 11 DD CC BB AA. The byte is stable during every stall, and outCmdReady = 0 until after the last byte.
5. CLR -> count = 0 and outHalted = 0. Opcode 0x7F -> accepted with no state change.
6. Preload count to 0xFFFFFFFF via RUN, then STEP -> count wraps to 0. Assert rst at byte 5 of a DUMP -> outTxValid drops asynchronously; after release the unit is in IDLE with outCmdReady = 1.
